// File: rtl/burst_read_fsm.sv
// Burst read controller: issues rd strobes per beat, honours slave wait states,
// pulses ds on completion. Optional WAIT timeout abort gated by BURST_READ_FSM_TIMEOUT_EN.
module burst_read_fsm #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             ws,
    output logic             rd,
    output logic             ds,
    output logic             err,
    output logic             busy,
    output logic [LEN_W-1:0] beat_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("burst_read_fsm: TIMEOUT must be in 1..255");
    end

    logic [2:0]       state, state_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [LEN_W-1:0] cnt_nxt;

`ifdef BURST_READ_FSM_TIMEOUT_EN
    localparam int unsigned WAIT_W = 8;
    logic [WAIT_W-1:0] wait_q, wait_nxt;
`endif

    // Next-state, length capture and beat/wait counting
    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        cnt_nxt   = beat_cnt;
`ifdef BURST_READ_FSM_TIMEOUT_EN
        wait_nxt  = wait_q;
`endif
        case (state)
            S_IDLE: begin
                if (go && (burst_len != '0)) begin
                    state_nxt = S_READ;
                    len_nxt   = burst_len;
                    cnt_nxt   = '0;
`ifdef BURST_READ_FSM_TIMEOUT_EN
                    wait_nxt  = '0;
`endif
                end
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!ws) begin
                    cnt_nxt   = beat_cnt + LEN_W'(1);
                    state_nxt = (cnt_nxt == len_q) ? S_DONE : S_READ;
`ifdef BURST_READ_FSM_TIMEOUT_EN
                    wait_nxt  = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT)) begin
                    state_nxt = S_ERR;
                end else begin
                    wait_nxt  = wait_q + WAIT_W'(1);
`endif
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: begin
                // Illegal encoding: recover to IDLE with every output cleared
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, captured length and registered Moore outputs decoded from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
            rd       <= 1'b0;
            ds       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            len_q    <= len_nxt;
            beat_cnt <= cnt_nxt;
            rd       <= (state_nxt == S_READ) || (state_nxt == S_WAIT);
            ds       <= (state_nxt == S_DONE);
            busy     <= (state_nxt != S_IDLE);
        end
    end

`ifdef BURST_READ_FSM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            err    <= 1'b0;
        end else begin
            wait_q <= wait_nxt;
            err    <= (state_nxt == S_ERR);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_read_fsm.sv
// Self-checking bench for burst_read_fsm: vector table, randomized bursts built
// from a per-beat wait plan, plus timeout and mid-burst reset sequences.
module tb_burst_read_fsm;

    localparam int unsigned LEN_W   = 4;
    localparam int unsigned TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             go;
    logic [LEN_W-1:0] burst_len;
    logic             ws;
    logic             rd, ds, err, busy;
    logic [LEN_W-1:0] beat_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             go;
        logic [LEN_W-1:0] len;
        logic             ws;
        logic             rd;
        logic             ds;
        logic             err;
        logic             busy;
        logic [LEN_W-1:0] cnt;
        string            name;
    } vec_t;

    burst_read_fsm #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .burst_len (burst_len),
        .ws        (ws),
        .rd        (rd),
        .ds        (ds),
        .err       (err),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic e_rd, input logic e_ds,
                         input logic e_err, input logic e_busy, input logic [LEN_W-1:0] e_cnt);
        total++;
        if ({rd, ds, err, busy, beat_cnt} !== {e_rd, e_ds, e_err, e_busy, e_cnt}) begin
            bad++;
            $display("FAIL %s: got rd=%b ds=%b err=%b busy=%b cnt=%0d, want rd=%b ds=%b err=%b busy=%b cnt=%0d",
                     name, rd, ds, err, busy, beat_cnt, e_rd, e_ds, e_err, e_busy, e_cnt);
        end
    endtask

    // Drive inputs, clock once, sample 1ns after the edge
    task automatic step(input logic g, input logic [LEN_W-1:0] l, input logic w, input string name,
                        input logic e_rd, input logic e_ds, input logic e_err, input logic e_busy,
                        input logic [LEN_W-1:0] e_cnt);
        go = g; burst_len = l; ws = w;
        @(posedge clk); #1;
        check(name, e_rd, e_ds, e_err, e_busy, e_cnt);
    endtask

    function automatic vec_t mk(input logic g, input int l, input logic w, input logic e_rd,
                                input logic e_ds, input logic e_busy, input int c, input string n);
        vec_t v;
        v.go = g; v.len = LEN_W'(l); v.ws = w;
        v.rd = e_rd; v.ds = e_ds; v.err = 1'b0; v.busy = e_busy; v.cnt = LEN_W'(c); v.name = n;
        return v;
    endfunction

    initial begin
        vec_t             tbl[$];
        logic [LEN_W-1:0] last_cnt;
        logic [LEN_W-1:0] blen;

        // go=1 len=3 on the first edge after reset, ws=0 throughout
        tbl.push_back(mk(1, 3, 0, 1, 0, 1, 0, "b3_read0"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, "b3_wait0"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, "b3_read1"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, "b3_wait1"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 2, "b3_read2"));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 2, "b3_wait2"));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 3, "b3_done"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, "b3_idle"));
        // zero length request is dropped
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3, "len0_drop"));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 3, "len0_drop2"));
        // len=2 with four wait states on beat 1, go pulsed while busy
        tbl.push_back(mk(1, 2, 1, 1, 0, 1, 0, "ws_read0"));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, "ws_wait0"));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, "ws_hold"));
        tbl.push_back(mk(1, 7, 0, 1, 0, 1, 1, "ws_read1"));
        tbl.push_back(mk(1, 9, 0, 1, 0, 1, 1, "ws_wait1"));
        tbl.push_back(mk(1, 5, 0, 0, 1, 1, 2, "ws_done"));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2, "ws_idle"));
        // go held high, len=1: READ, WAIT, DONE, IDLE repeating
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, "rep_read"));
            tbl.push_back(mk(1, 1, 0, 1, 0, 1, 0, "rep_wait"));
            tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, "rep_done"));
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, "rep_idle"));
        end

        rst_n = 1'b0; go = 1'b0; ws = 1'b0; burst_len = '0;
        #1 check("reset_async", 0, 0, 0, 0, '0);
        go = 1'b1; burst_len = LEN_W'(2);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", 0, 0, 0, 0, '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            step(tbl[i].go, tbl[i].len, tbl[i].ws, tbl[i].name,
                 tbl[i].rd, tbl[i].ds, tbl[i].err, tbl[i].busy, tbl[i].cnt);
        step(0, '0, 0, "tbl_end_idle", 0, 0, 0, 0, LEN_W'(1));
        last_cnt = LEN_W'(1);

        // Random bursts: expected trace follows from the per-beat wait plan
        for (int n = 0; n < 30; n++) begin
            int gap;
            int beats;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                step(1'($urandom_range(0, 1)), '0, 1'($urandom_range(0, 1)), "rnd_gap",
                     0, 0, 0, 0, last_cnt);
            beats = (n == 0) ? 15 : $urandom_range(1, 15);
            blen  = LEN_W'(beats);
            step(1, blen, 1'($urandom_range(0, 1)), "rnd_start", 1, 0, 0, 1, '0);
            for (int b = 0; b < beats; b++) begin
                int k;
                step(1'($urandom_range(0, 1)), LEN_W'($urandom), 1'($urandom_range(0, 1)),
                     "rnd_wait_enter", 1, 0, 0, 1, LEN_W'(b));
                k = $urandom_range(0, 5);
                for (int j = 0; j < k; j++)
                    step(1'($urandom_range(0, 1)), LEN_W'($urandom), 1, "rnd_wait_hold",
                         1, 0, 0, 1, LEN_W'(b));
                step(1'($urandom_range(0, 1)), LEN_W'($urandom), 0, "rnd_beat",
                     (b + 1 != beats), (b + 1 == beats), 0, 1, LEN_W'(b + 1));
            end
            step(1'($urandom_range(0, 1)), LEN_W'($urandom), 1'($urandom_range(0, 1)),
                 "rnd_back_idle", 0, 0, 0, 0, blen);
            last_cnt = blen;
        end
        step(0, '0, 0, "rnd_end_idle", 0, 0, 0, 0, last_cnt);

        // ws stuck high on beat 2 of a 4-beat burst
        step(1, LEN_W'(4), 0, "to_read0", 1, 0, 0, 1, '0);
        step(0, '0, 0, "to_wait0", 1, 0, 0, 1, '0);
        step(0, '0, 0, "to_read1", 1, 0, 0, 1, LEN_W'(1));
        step(0, '0, 1, "to_wait1", 1, 0, 0, 1, LEN_W'(1));
`ifdef BURST_READ_FSM_TIMEOUT_EN
        for (int i = 0; i < int'(TIMEOUT); i++)
            step(0, '0, 1, "to_hold", 1, 0, 0, 1, LEN_W'(1));
        step(0, '0, 1, "to_err", 0, 0, 1, 1, LEN_W'(1));
        step(0, '0, 1, "to_idle", 0, 0, 0, 0, LEN_W'(1));
`else
        for (int i = 0; i < 40; i++)
            step(1, LEN_W'(3), 1, "to_stay_wait", 1, 0, 0, 1, LEN_W'(1));
        step(0, '0, 0, "to_read2", 1, 0, 0, 1, LEN_W'(2));
        step(0, '0, 0, "to_wait2", 1, 0, 0, 1, LEN_W'(2));
        step(0, '0, 0, "to_read3", 1, 0, 0, 1, LEN_W'(3));
        step(0, '0, 0, "to_wait3", 1, 0, 0, 1, LEN_W'(3));
        step(0, '0, 0, "to_done", 0, 1, 0, 1, LEN_W'(4));
        step(0, '0, 0, "to_idle", 0, 0, 0, 0, LEN_W'(4));
`endif

        // Asynchronous reset in beat 3 of an 8-beat burst
        step(1, LEN_W'(8), 0, "rs_read0", 1, 0, 0, 1, '0);
        step(0, '0, 0, "rs_wait0", 1, 0, 0, 1, '0);
        step(0, '0, 0, "rs_read1", 1, 0, 0, 1, LEN_W'(1));
        step(0, '0, 0, "rs_wait1", 1, 0, 0, 1, LEN_W'(1));
        step(0, '0, 0, "rs_read2", 1, 0, 0, 1, LEN_W'(2));
        step(0, '0, 1, "rs_wait2", 1, 0, 0, 1, LEN_W'(2));
        #3 rst_n = 1'b0;
        #1 check("rs_async", 0, 0, 0, 0, '0);
        @(negedge clk);
        rst_n = 1'b1; go = 1'b0; ws = 1'b0;
        @(posedge clk); #1;
        check("rs_no_pulse", 0, 0, 0, 0, '0);
        step(1, LEN_W'(1), 0, "rs_fresh_read", 1, 0, 0, 1, '0);
        step(0, '0, 0, "rs_fresh_wait", 1, 0, 0, 1, '0);
        step(0, '0, 0, "rs_fresh_done", 0, 1, 0, 1, LEN_W'(1));
        step(0, '0, 0, "rs_fresh_idle", 0, 0, 0, 0, LEN_W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_read_fsm.md
BURST_READ_FSM -- requirements
Module: burst_read_fsm

Interface
REQ-001 SHALL have parameter LEN_W, default 4, width of burst_len and beat_cnt.
REQ-002 SHALL have parameter TIMEOUT, default 15, max consecutive WAIT cycles with ws=1 before abort (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port go  input  1  start request, sampled in IDLE only.
REQ-006 SHALL have port burst_len  input  LEN_W  beats per burst, captured when go accepted.
REQ-007 SHALL have port ws  input  1  wait-state from slave; 1 = beat not yet accepted.
REQ-008 SHALL have port rd  output  1  read strobe.
REQ-009 SHALL have port ds  output  1  done strobe, one-cycle pulse.
REQ-010 SHALL have port err  output  1  timeout abort, one-cycle pulse.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port beat_cnt  output  LEN_W  beats completed in current burst.

Function
REQ-013 SHALL implement five states: IDLE, READ, WAIT, DONE, ERR, encoded in a 3-bit register.
REQ-014 All outputs SHALL be registered Moore outputs, with no combinational path from inputs to outputs.
REQ-015 IDLE: go=1 and burst_len!=0 -> READ, capturing burst_len into len_q and clearing beat_cnt and wait counter; go=1 with burst_len=0 -> stay IDLE, request dropped.
REQ-016 READ: rd=1; unconditionally -> WAIT next cycle.
REQ-017 WAIT: rd=1; ws=1 -> stay WAIT and increment wait counter; ws=0 -> beat accepted, beat_cnt+1, wait counter cleared.
REQ-018 WAIT with ws=0: if beat_cnt+1==len_q -> DONE, else -> READ.
REQ-019 DONE: ds=1, rd=0 for exactly one cycle; -> IDLE.
REQ-020 ERR: err=1, rd=0 for exactly one cycle; -> IDLE; beat_cnt holds the count of completed beats through ERR.
REQ-021 go SHALL be ignored while busy=1; no queuing.
REQ-022 burst_len changes after capture SHALL have no effect on the running burst.
REQ-023 burst_len at max value (2^LEN_W-1) SHALL complete that many beats, and beat_cnt SHALL never wrap.
REQ-024 Latency: go accepted at edge N -> rd=1 from N+1; minimum burst of 1 beat with ws=0 -> ds=1 at edge N+3.
REQ-025 From IDLE, go=1 on the cycle DONE or ERR returns to IDLE SHALL be accepted, giving back-to-back bursts with one IDLE cycle between them.
REQ-026 Any unused state encoding SHALL return to IDLE on the next edge, with all outputs 0.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE and rd=0, ds=0, err=0, busy=0, beat_cnt=0, len_q=0, wait counter=0, independent of clk.
REQ-028 Reset asserted mid-burst SHALL abort the burst with no ds or err pulse.
REQ-029 After rst_n deasserts, the first go SHALL be sampled at the first rising edge.

Configuration
REQ-030 Macro BURST_READ_FSM_TIMEOUT_EN SHALL gate the timeout feature.
REQ-031 With the macro defined: wait counter reaching TIMEOUT with ws still 1 -> ERR on the next edge.
REQ-032 With the macro undefined: WAIT SHALL hold indefinitely while ws=1, ERR SHALL be unreachable, err SHALL be tied 0, and no wait counter SHALL be present.

Verification
REQ-033 Reset then go=1, burst_len=3, ws=0 always -> rd pattern 1,1,1,1,1,1 over 6 cycles, ds=1 on cycle 7, beat_cnt=3, then IDLE.
REQ-034 go=1, burst_len=2, ws=1 for 4 cycles on beat 1 -> WAIT held 5 cycles, rd stays 1, ds after beat 2, err=0.
REQ-035 TIMEOUT_EN defined, TIMEOUT=15, burst_len=4, ws stuck 1 on beat 2 -> err=1 one cycle after 15 wait cycles, beat_cnt=1, then IDLE; undefined -> no err, FSM stays in WAIT.
REQ-036 go=1 with burst_len=0 -> busy stays 0, rd stays 0; go pulsed during a burst of burst_len=5 -> ignored, exactly 5 beats.
REQ-037 rst_n pulled low between edges in beat 3 of 8 -> rd, busy, beat_cnt=0 immediately with no ds; next go starts a fresh burst.
REQ-038 go held 1 with burst_len=1, ws=0 -> repeating sequence READ,WAIT,DONE,IDLE with ds every 4 cycles.
